// File: rtl/line_engine_pkg.sv
// Shared types and default geometry for the Bresenham line engine.
package line_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_DRAW
   } state_t;

   localparam logic [31:0] DEF_FB_BASE = 32'h1000_0000;
   localparam int unsigned DEF_H_RES   = 800;
   localparam int unsigned DEF_V_RES   = 600;

endpackage

// File: rtl/line_engine_setup.sv
// Combinational Bresenham setup: orders the endpoints so the walk always runs
// along +x of the major axis, and derives the step constants.
module line_engine_setup (
   input  logic [9:0]         x0_i,
   input  logic [9:0]         y0_i,
   input  logic [9:0]         x1_i,
   input  logic [9:0]         y1_i,
   output logic               steep_o,
   output logic [9:0]         sx_o,
   output logic [9:0]         sy_o,
   output logic [9:0]         ex_o,
   output logic [10:0]        dx_o,
   output logic [10:0]        dy_o,
   output logic               yneg_o,
   output logic signed [11:0] err_o
);

   logic [9:0] adx, ady;
   logic [9:0] a0, b0, a1, b1;
   logic [9:0] ey;

   always_comb begin
      adx     = (x1_i >= x0_i) ? (x1_i - x0_i) : (x0_i - x1_i);
      ady     = (y1_i >= y0_i) ? (y1_i - y0_i) : (y0_i - y1_i);
      steep_o = ady > adx;

      // a is the major axis after the steep swap, b the minor one
      a0 = steep_o ? y0_i : x0_i;
      b0 = steep_o ? x0_i : y0_i;
      a1 = steep_o ? y1_i : x1_i;
      b1 = steep_o ? x1_i : y1_i;

      if (a0 > a1) begin
         sx_o = a1;
         sy_o = b1;
         ex_o = a0;
         ey   = b0;
      end else begin
         sx_o = a0;
         sy_o = b0;
         ex_o = a1;
         ey   = b1;
      end

      dx_o   = {1'b0, ex_o - sx_o};
      dy_o   = {1'b0, (ey >= sy_o) ? (ey - sy_o) : (sy_o - ey)};
      yneg_o = sy_o > ey;
      err_o  = $signed({2'b00, dx_o[10:1]});
   end

endmodule

// File: rtl/line_engine.sv
// Bresenham line rasteriser: latches endpoints/colour from the CPU port and
// emits one framebuffer pixel write per accepted step, clipping off-screen pixels.
module line_engine
   import line_engine_pkg::*;
#(
   parameter logic [31:0] FB_BASE = DEF_FB_BASE,
   parameter int unsigned H_RES   = DEF_H_RES,
   parameter int unsigned V_RES   = DEF_V_RES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] line_color,
   input  logic [9:0]  line_point,
   input  logic        line_color_valid,
   input  logic        line_x0_valid,
   input  logic        line_y0_valid,
   input  logic        line_x1_valid,
   input  logic        line_y1_valid,
   input  logic        line_trigger,
   output logic        line_ready,
   output logic        px_valid,
   input  logic        px_ready,
   output logic [31:0] px_addr,
   output logic [31:0] px_wdata
);

   localparam logic [10:0] H_LIM = 11'(H_RES);
   localparam logic [10:0] V_LIM = 11'(V_RES);

   state_t state_q, state_d;

   logic [23:0] color_q;
   logic [9:0]  x0_q, y0_q, x1_q, y1_q;

   logic [9:0]         x_q, y_q, xe_q;
   logic [10:0]        dx_q, dy_q;
   logic signed [11:0] err_q;
   logic               steep_q, yneg_q;

   logic               su_steep, su_yneg;
   logic [9:0]         su_sx, su_sy, su_ex;
   logic [10:0]        su_dx, su_dy;
   logic signed [11:0] su_err;

   logic [9:0]         plot_x, plot_y;
   logic               clip, draw, advance;
   logic signed [11:0] err_dec, err_d;
   logic [9:0]         y_d;

   line_engine_setup u_setup (
      .x0_i   (x0_q),
      .y0_i   (y0_q),
      .x1_i   (x1_q),
      .y1_i   (y1_q),
      .steep_o(su_steep),
      .sx_o   (su_sx),
      .sy_o   (su_sy),
      .ex_o   (su_ex),
      .dx_o   (su_dx),
      .dy_o   (su_dy),
      .yneg_o (su_yneg),
      .err_o  (su_err)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      draw       = (state_q == ST_DRAW);
      line_ready = (state_q == ST_IDLE);

      plot_x   = steep_q ? y_q : x_q;
      plot_y   = steep_q ? x_q : y_q;
      clip     = ({1'b0, plot_x} >= H_LIM) || ({1'b0, plot_y} >= V_LIM);
      px_valid = draw && !clip;
      advance  = draw && (clip || px_ready);

      err_dec = err_q - $signed({1'b0, dy_q});
      err_d   = err_dec;
      y_d     = y_q;
      if (err_dec[11]) begin
         y_d   = yneg_q ? (y_q - 10'd1) : (y_q + 10'd1);
         err_d = err_dec + $signed({1'b0, dx_q});
      end

      px_addr  = draw ? (FB_BASE + {10'b0, plot_y, 12'b0} + {20'b0, plot_x, 2'b0}) : 32'h0;
      px_wdata = {8'h00, color_q};

      case (state_q)
         ST_IDLE:  if (line_trigger) state_d = ST_SETUP;
         ST_SETUP: state_d = ST_DRAW;
         ST_DRAW:  if (advance && (x_q == xe_q)) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         color_q <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         xe_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         steep_q <= 1'b0;
         yneg_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values of the others.
         state_q <= state_d;

         // strobes landing with the trigger are captured in time for SETUP
         if (state_q == ST_IDLE) begin
            if (line_color_valid) color_q <= line_color[23:0];
            if (line_x0_valid)    x0_q    <= line_point;
            if (line_y0_valid)    y0_q    <= line_point;
            if (line_x1_valid)    x1_q    <= line_point;
            if (line_y1_valid)    y1_q    <= line_point;
         end

         if (state_q == ST_SETUP) begin
            x_q     <= su_sx;
            y_q     <= su_sy;
            xe_q    <= su_ex;
            dx_q    <= su_dx;
            dy_q    <= su_dy;
            err_q   <= su_err;
            steep_q <= su_steep;
            yneg_q  <= su_yneg;
         end else if (advance) begin
            x_q   <= x_q + 10'd1;
            y_q   <= y_d;
            err_q <= err_d;
         end
      end
   end

endmodule

// File: tb/tb_line_engine.sv
// Directed self-checking bench for line_engine: geometry, backpressure, clipping,
// same-cycle strobes, busy-time control and mid-line reset.
module tb_line_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] line_color;
   logic [9:0]  line_point;
   logic        line_color_valid, line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid;
   logic        line_trigger;
   logic        line_ready;
   logic        px_valid;
   logic        px_ready;
   logic [31:0] px_addr;
   logic [31:0] px_wdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];
   int          stall_err = 0;
   int          stalls    = 0;
   logic        stall_q   = 1'b0;
   logic [31:0] hold_addr, hold_data;
   logic        bp_mode   = 1'b0;

   always #5 clk = ~clk;

   line_engine dut (
      .clk             (clk),
      .rst             (rst),
      .line_color      (line_color),
      .line_point      (line_point),
      .line_color_valid(line_color_valid),
      .line_x0_valid   (line_x0_valid),
      .line_y0_valid   (line_y0_valid),
      .line_x1_valid   (line_x1_valid),
      .line_y1_valid   (line_y1_valid),
      .line_trigger    (line_trigger),
      .line_ready      (line_ready),
      .px_valid        (px_valid),
      .px_ready        (px_ready),
      .px_addr         (px_addr),
      .px_wdata        (px_wdata)
   );

   // write monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (!rst) begin
         if (px_valid && px_ready) begin
            q_addr.push_back(px_addr);
            q_data.push_back(px_wdata);
         end
         if (stall_q && (!px_valid || px_addr !== hold_addr || px_wdata !== hold_data))
            stall_err++;
         stall_q   = px_valid && !px_ready;
         if (stall_q) stalls++;
         hold_addr = px_addr;
         hold_data = px_wdata;
      end else begin
         stall_q = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pa(input int x, input int y);
      return 32'h1000_0000 + 32'(y * 4096) + 32'(x * 4);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_mode) px_ready = ~px_ready;
   endtask

   task automatic strobe(input int sel, input logic [9:0] v);
      line_point = v;
      case (sel)
         0: line_x0_valid = 1'b1;
         1: line_y0_valid = 1'b1;
         2: line_x1_valid = 1'b1;
         default: line_y1_valid = 1'b1;
      endcase
      tick();
      {line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid} = '0;
   endtask

   task automatic trigger();
      line_trigger = 1'b1;
      tick();
      line_trigger = 1'b0;
   endtask

   task automatic start_line(input int x0, input int y0, input int x1, input int y1,
                             input logic [31:0] color);
      line_color       = color;
      line_color_valid = 1'b1;
      strobe(0, 10'(x0));
      line_color_valid = 1'b0;
      strobe(1, 10'(y0));
      strobe(2, 10'(x1));
      strobe(3, 10'(y1));
      trigger();
   endtask

   task automatic wait_idle(input string tag, output int cycles);
      cycles = 0;
      while (!line_ready && cycles < 2000) begin
         tick();
         cycles++;
      end
      check({tag, "_idle"}, {31'b0, line_ready}, 32'd1);
   endtask

   task automatic clear_q();
      q_addr.delete();
      q_data.delete();
   endtask

   int cyc;
   int n_before;
   int t2_x[6] = '{0, 0, 1, 1, 2, 2};
   int t2_y[6] = '{0, 1, 2, 3, 4, 5};
   logic [31:0] t1_addr[4] = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C};

   initial begin
      rst = 1'b1;
      px_ready = 1'b1;
      line_color = '0;
      line_point = '0;
      {line_color_valid, line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid} = '0;
      line_trigger = 1'b0;
      #1;
      check("rst_ready", {31'b0, line_ready}, 32'd1);
      check("rst_pv", {31'b0, px_valid}, 32'd0);
      check("rst_addr", px_addr, 32'h0);
      check("rst_wdata", px_wdata, 32'h0);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 1: horizontal line, exact latency
      clear_q();
      start_line(0, 0, 3, 0, 32'h00FF_0000);
      check("t1_setup_ready", {31'b0, line_ready}, 32'd0);
      check("t1_setup_pv", {31'b0, px_valid}, 32'd0);
      tick();
      check("t1_first_pv", {31'b0, px_valid}, 32'd1);
      check("t1_first_addr", px_addr, 32'h1000_0000);
      repeat (3) tick();
      check("t1_last_busy", {31'b0, line_ready}, 32'd0);
      tick();
      check("t1_ready_back", {31'b0, line_ready}, 32'd1);
      check("t1_pv_off", {31'b0, px_valid}, 32'd0);
      check("t1_count", 32'(q_addr.size()), 32'd4);
      for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
         check($sformatf("t1_addr%0d", i), q_addr[i], t1_addr[i]);
         check($sformatf("t1_data%0d", i), q_data[i], 32'h00FF_0000);
      end

      // 2: steep reversed line
      clear_q();
      start_line(2, 5, 0, 0, 32'hAB12_3456);
      wait_idle("t2", cyc);
      check("t2_count", 32'(q_addr.size()), 32'd6);
      for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
         check($sformatf("t2_addr%0d", i), q_addr[i], pa(t2_x[i], t2_y[i]));
         check($sformatf("t2_data%0d", i), q_data[i], 32'h0012_3456);
      end

      // 3: backpressure with px_ready toggling
      clear_q();
      stall_err = 0;
      stalls = 0;
      bp_mode = 1'b1;
      start_line(0, 0, 3, 0, 32'h00FF_0000);
      wait_idle("t3", cyc);
      bp_mode = 1'b0;
      px_ready = 1'b1;
      check("t3_count", 32'(q_addr.size()), 32'd4);
      for (int i = 0; i < 4 && i < q_addr.size(); i++)
         check($sformatf("t3_addr%0d", i), q_addr[i], t1_addr[i]);
      check("t3_stable", 32'(stall_err), 32'd0);
      check("t3_stalled", {31'b0, stalls != 0}, 32'd1);

      // 4: y1 strobed together with trigger, then a single-point line
      clear_q();
      line_color = 32'h0000_0077;
      line_color_valid = 1'b1;
      strobe(0, 10'd7);
      line_color_valid = 1'b0;
      strobe(1, 10'd7);
      strobe(2, 10'd7);
      line_point = 10'd9;
      line_y1_valid = 1'b1;
      line_trigger = 1'b1;
      tick();
      line_y1_valid = 1'b0;
      line_trigger = 1'b0;
      wait_idle("t4a", cyc);
      check("t4a_count", 32'(q_addr.size()), 32'd3);
      for (int i = 0; i < 3 && i < q_addr.size(); i++)
         check($sformatf("t4a_addr%0d", i), q_addr[i], pa(7, 7 + i));
      clear_q();
      strobe(1, 10'd9);
      trigger();
      wait_idle("t4b", cyc);
      check("t4b_count", 32'(q_addr.size()), 32'd1);
      if (q_addr.size() > 0) check("t4b_addr", q_addr[0], 32'h1000_901C);

      // 5: clipping at the right edge
      clear_q();
      start_line(798, 0, 801, 0, 32'h0000_00FF);
      wait_idle("t5", cyc);
      check("t5_cycles", 32'(cyc), 32'd5);
      check("t5_count", 32'(q_addr.size()), 32'd2);
      if (q_addr.size() > 1) begin
         check("t5_addr0", q_addr[0], 32'h1000_0C78);
         check("t5_addr1", q_addr[1], 32'h1000_0C7C);
      end

      // 6a: strobes and trigger while busy are ignored
      clear_q();
      start_line(0, 0, 3, 0, 32'h0012_0000);
      line_point = 10'd100;
      line_color = 32'h00AB_CDEF;
      {line_color_valid, line_x1_valid, line_y1_valid, line_trigger} = 4'b1111;
      repeat (2) tick();
      {line_color_valid, line_x1_valid, line_y1_valid, line_trigger} = 4'b0000;
      wait_idle("t6a", cyc);
      check("t6a_count", 32'(q_addr.size()), 32'd4);
      if (q_addr.size() > 3) begin
         check("t6a_last", q_addr[3], 32'h1000_000C);
         check("t6a_data", q_data[3], 32'h0012_0000);
      end
      tick();
      check("t6a_no_retrigger", 32'(q_addr.size()), 32'd4);
      clear_q();
      trigger();
      wait_idle("t6b", cyc);
      check("t6b_count", 32'(q_addr.size()), 32'd4);
      if (q_addr.size() > 3) begin
         check("t6b_last", q_addr[3], 32'h1000_000C);
         check("t6b_data", q_data[3], 32'h0012_0000);
      end

      // 6c: reset mid-line
      clear_q();
      start_line(0, 0, 9, 0, 32'h0000_1111);
      repeat (3) tick();
      n_before = q_addr.size();
      check("t6c_before", 32'(n_before), 32'd2);
      rst = 1'b1;
      #1;
      check("t6c_pv", {31'b0, px_valid}, 32'd0);
      check("t6c_ready", {31'b0, line_ready}, 32'd1);
      check("t6c_addr", px_addr, 32'h0);
      check("t6c_wdata", px_wdata, 32'h0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (5) tick();
      check("t6c_no_more", 32'(q_addr.size()), 32'(n_before));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
